tx_port_arbiter: RTL and testbench

//  Shares one serial transmitter (55-bit frame, TX_Data/TX_Data_Valid/TX_Ready) among NUM_REQ router

---
 rtl/tx_port_arbiter.sv | 112 +++++++++++
 tb/tb_tx_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_port_arbiter.sv
// Round-robin arbiter with token credit flow control that shares one serial transmitter
// among NUM_REQ requesters and holds each granted frame stable until it is acknowledged.
module tx_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 55,
  parameter int CREDIT_W    = 4,
  parameter int CREDIT_INIT = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      Clk_S,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Req_Ack,
  input  logic                      Token_In,
  input  logic                      TX_Ready,
  output logic [DATA_W-1:0]         TX_Data,
  output logic                      TX_Data_Valid,
  output logic [ID_W-1:0]           Grant_Id,
  output logic [CREDIT_W-1:0]       Credits,
  output logic                      Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   eligible;
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      winner;
  logic                 any_eligible;
  logic                 grant;
  logic                 ack_set;
  logic [CREDIT_W-1:0]  credits_q;

  // A requester being acked this cycle must not win again on its stale Req_Valid.
  assign eligible = Req_Valid & ~Req_Ack;

  always_comb begin
    int idx;
    idx          = 0;
    winner       = last_q;
    any_eligible = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!any_eligible && eligible[idx]) begin
        winner       = ID_W'(idx);
        any_eligible = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_set   = 1'b0;
    case (state)
      IDLE: begin
        if (any_eligible && (credits_q != '0) && TX_Ready) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!TX_Ready) state_nxt = BUSY;
      end
      BUSY: begin
        if (TX_Ready) begin
          ack_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      TX_Data  <= '0;
      Grant_Id <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
      Req_Ack  <= '0;
    end else begin
      Req_Ack <= ack_set ? (NUM_REQ'(1) << Grant_Id) : '0;
      if (grant) begin
        TX_Data  <= Req_Data[int'(winner)*DATA_W +: DATA_W];
        Grant_Id <= winner;
        last_q   <= winner;
      end
    end
  end

  // Token and grant in the same cycle cancel out; tokens saturate at the counter maximum.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      credits_q <= CREDIT_W'(CREDIT_INIT);
    end else if (Token_In && !grant && (credits_q != '1)) begin
      credits_q <= credits_q + 1'b1;
    end else if (grant && !Token_In) begin
      credits_q <= credits_q - 1'b1;
    end
  end

  assign TX_Data_Valid = (state == ISSUE);
  assign Busy          = (state != IDLE);
  assign Credits       = credits_q;

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Randomised self-checking bench for tx_port_arbiter: a transaction-level reference model,
// a segment-serial transmitter model and per-cycle comparison of every output.
module tb_tx_port_arbiter;
  localparam int N       = 4;
  localparam int W       = 55;
  localparam int CMAX    = 15;
  localparam int SEG     = 11;
  localparam int NSEG    = W / SEG;

  logic             Clk_S;
  logic             Rst_n;
  logic [N-1:0]     Req_Valid;
  logic [N*W-1:0]   Req_Data;
  logic [N-1:0]     Req_Ack;
  logic             Token_In;
  logic             TX_Ready;
  logic [W-1:0]     TX_Data;
  logic             TX_Data_Valid;
  logic [1:0]       Grant_Id;
  logic [3:0]       Credits;
  logic             Busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int req_prob = 0;
  int tok_prob = 0;
  bit scramble_en = 0;

  // reference model: frame in flight, whether it is still being offered, latched frame
  bit           m_in_flight, m_offering;
  logic [W-1:0] m_data;
  int           m_gid, m_last, m_credits;
  logic [N-1:0] m_ack;

  // transmitter model
  bit           tx_active;
  int           tx_wait, tx_seg;
  logic [W-1:0] ser_buf;

  tx_port_arbiter #(.NUM_REQ(N), .DATA_W(W), .CREDIT_W(4), .CREDIT_INIT(4)) dut (
    .Clk_S(Clk_S), .Rst_n(Rst_n), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ack(Req_Ack), .Token_In(Token_In), .TX_Ready(TX_Ready), .TX_Data(TX_Data),
    .TX_Data_Valid(TX_Data_Valid), .Grant_Id(Grant_Id), .Credits(Credits), .Busy(Busy)
  );

  initial Clk_S = 0;
  always #5 Clk_S = ~Clk_S;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      m_in_flight = 0; m_offering = 0; m_data = '0; m_gid = 0;
      m_last = N - 1; m_credits = 4; m_ack = '0;
    end else begin
      logic [N-1:0] elig;
      logic [N-1:0] new_ack;
      int win, c;
      bit g;
      new_ack = '0;
      g = 0;
      win = -1;
      if (!m_in_flight) begin
        elig = Req_Valid & ~m_ack;
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && elig[(m_last + k) % N]) win = (m_last + k) % N;
        end
        if (win >= 0 && m_credits > 0 && TX_Ready) begin
          g = 1;
          m_in_flight = 1; m_offering = 1;
          m_data = Req_Data[win*W +: W];
          m_gid = win; m_last = win;
        end
      end else if (m_offering) begin
        if (!TX_Ready) m_offering = 0;
      end else if (TX_Ready) begin
        new_ack[m_gid] = 1'b1;
        m_in_flight = 0;
      end
      c = m_credits + int'(Token_In) - int'(g);
      m_credits = (c > CMAX) ? CMAX : c;
      m_ack = new_ack;
    end
  end

  always @(negedge Clk_S) begin
    if (chk_en) begin
      checkOutput("tx_valid", TX_Data_Valid, m_in_flight && m_offering);
      checkOutput("tx_data", TX_Data, m_data);
      checkOutput("grant_id", Grant_Id, m_gid);
      checkOutput("credits", Credits, m_credits);
      checkOutput("busy", Busy, m_in_flight);
      checkOutput("req_ack", Req_Ack, m_ack);
    end
  end

  // Accepts an offered frame after a random delay, then reads it one 11-bit segment per cycle.
  task automatic txModel();
    if (!Rst_n) begin
      tx_active = 0; TX_Ready = 1;
    end else if (!tx_active) begin
      if (TX_Data_Valid && TX_Ready) begin
        if (tx_wait == 0) begin
          TX_Ready = 0; tx_active = 1; tx_seg = 0;
        end else tx_wait--;
      end else tx_wait = $urandom_range(0, 2);
    end else begin
      ser_buf[tx_seg*SEG +: SEG] = TX_Data[tx_seg*SEG +: SEG];
      tx_seg++;
      if (tx_seg == NSEG) begin
        checkOutput("serial_frame", ser_buf, m_data);
        TX_Ready = 1; tx_active = 0; tx_wait = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic applyStimulus();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      if (Req_Valid[i] && Req_Ack[i]) begin
        Req_Valid[i] = 0;
      end else if (!Req_Valid[i] && ($urandom_range(0, 99) < req_prob)) begin
        r = {$urandom(), $urandom()};
        Req_Data[i*W +: W] = r[W-1:0];
        Req_Valid[i] = 1;
      end
    end
    if (scramble_en && m_in_flight && !m_offering && ($urandom_range(0, 3) == 0)) begin
      r = {$urandom(), $urandom()};
      Req_Data[m_gid*W +: W] = r[W-1:0];
    end
    Token_In = ($urandom_range(0, 99) < tok_prob);
  endtask

  task automatic stepCycle();
    @(negedge Clk_S);
    txModel();
    applyStimulus();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit done;
    Rst_n = 0; Req_Valid = '0; Req_Data = '0; Token_In = 0; TX_Ready = 1;
    tx_active = 0; tx_wait = 0; tx_seg = 0; ser_buf = '0;
    repeat (3) @(negedge Clk_S);
    checkOutput("reset_credits", Credits, 4);
    checkOutput("reset_valid", TX_Data_Valid, 0);
    Rst_n = 1;
    chk_en = 1;
    @(negedge Clk_S);
    checkOutput("init_credits", Credits, 4);
    checkOutput("init_grant", Grant_Id, 0);
    checkOutput("init_busy", Busy, 0);

    // single requester, first frame
    Req_Data[0 +: W] = 55'h12345;
    Req_Valid = 4'b0001;
    @(posedge Clk_S); #1;
    checkOutput("t1_valid", TX_Data_Valid, 1);
    checkOutput("t1_data", TX_Data, 55'h12345);
    checkOutput("t1_grant", Grant_Id, 0);
    checkOutput("t1_credits_dec", Credits, 3);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      stepCycle();
      if (Req_Valid[0] == 0) done = 1;
    end
    checkOutput("t1_acked", done, 1);
    checkOutput("t1_credits", Credits, 3);

    // token saturation
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      Token_In = 1;
      stepCycle();
    end
    checkOutput("t4_saturate", Credits, 15);

    // heavy traffic with scarce tokens drains credits to zero repeatedly
    req_prob = 40; tok_prob = 8; scramble_en = 1;
    repeat (1500) stepCycle();

    // reset in the middle of serialisation
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      stepCycle();
      if (m_in_flight && !m_offering) done = 1;
    end
    checkOutput("t6_reach_busy", done, 1);
    #2;
    Rst_n = 0;
    TX_Ready = 1; tx_active = 0;
    #1;
    checkOutput("t6_valid", TX_Data_Valid, 0);
    checkOutput("t6_data", TX_Data, 0);
    checkOutput("t6_busy", Busy, 0);
    checkOutput("t6_ack", Req_Ack, 0);
    checkOutput("t6_credits", Credits, 4);
    checkOutput("t6_grant", Grant_Id, 0);
    repeat (2) @(negedge Clk_S);
    Rst_n = 1;

    req_prob = 30; tok_prob = 30;
    repeat (1500) stepCycle();

    // let outstanding requests finish
    req_prob = 0; tok_prob = 25; scramble_en = 0;
    repeat (400) stepCycle();
    checkOutput("drain_idle", Req_Valid, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
